// File: rtl/array_sort_check_datapath.sv
// array_sort_check_datapath: array memory, base/length/index registers and adjacent-pair order flags.
// Define ARRAY_SORT_CHECK_SIGNED_EN for a two's-complement comparison; default compares unsigned.
module array_sort_check_datapath #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_input,
  input  logic              load_index,
  input  logic              select_index,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [ADDR_W:0]   length_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              inversion_found,
  output logic              end_of_array,
  output logic              zero_length_array,
  output logic [ADDR_W-1:0] index_out
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] base_q, base_d, idx_q, idx_d, addr_a, addr_b;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W+1:0] idx_p2, len_x;
  logic [WIDTH-1:0]  a, b;
  logic              a_gt_b, pair_valid;
  always_comb begin
    base_d = load_input ? base_in : base_q;
    len_d  = load_input ? length_in : len_q;
    idx_d  = load_index ? (select_index ? idx_q + 1'b1 : '0) : idx_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end
  always_ff @(posedge clock) if (wr_en) mem_q[wr_addr] <= wr_data;
  // Address arithmetic is ADDR_W bits wide so reads wrap past the top of memory.
  always_comb begin
    addr_a = base_q + idx_q;
    addr_b = addr_a + 1'b1;
    a      = mem_q[addr_a];
    b      = mem_q[addr_b];
`ifdef ARRAY_SORT_CHECK_SIGNED_EN
    a_gt_b = $signed(a) > $signed(b);
`else
    a_gt_b = a > b;
`endif
    idx_p2 = {2'b00, idx_q} + (ADDR_W+2)'(2);
    len_x  = {1'b0, len_q};
    pair_valid        = idx_p2 <= len_x;
    inversion_found   = pair_valid & a_gt_b;
    end_of_array      = (idx_p2 >= len_x) & ~inversion_found;
    zero_length_array = len_q == '0;
    index_out         = idx_q;
  end
endmodule

// File: tb/tb_array_sort_check_datapath.sv
// tb_array_sort_check_datapath: directed checks of the sort-check datapath flags and index.
module tb_array_sort_check_datapath;
  logic        clock = 0, reset = 1, load_input = 0, load_index = 0, select_index = 0, wr_en = 0;
  logic [3:0]  base_in = 0, wr_addr = 0;
  logic [4:0]  length_in = 0;
  logic [31:0] wr_data = 0;
  logic        inversion_found, end_of_array, zero_length_array;
  logic [3:0]  index_out;
  int          errors = 0, checks = 0;
  array_sort_check_datapath dut (
    .clock(clock), .reset(reset), .load_input(load_input), .load_index(load_index),
    .select_index(select_index), .base_in(base_in), .length_in(length_in), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .inversion_found(inversion_found),
    .end_of_array(end_of_array), .zero_length_array(zero_length_array), .index_out(index_out)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    wr_en = 1; wr_addr = addr; wr_data = data;
    step();
    wr_en = 0;
  endtask
  task automatic start(input logic [3:0] base, input logic [4:0] len);
    load_input = 1; base_in = base; length_in = len;
    load_index = 1; select_index = 0;
    step();
    load_input = 0; load_index = 0;
  endtask
  task automatic inc();
    load_index = 1; select_index = 1;
    step();
    load_index = 0;
  endtask
  task automatic flags(input string tag, input logic inv, input logic eoa, input logic zl);
    chk({tag, "_inv"}, 32'(inversion_found), 32'(inv));
    chk({tag, "_end"}, 32'(end_of_array), 32'(eoa));
    chk({tag, "_zero"}, 32'(zero_length_array), 32'(zl));
  endtask
  initial begin
    step();
    reset = 0;
    chk("reset_idx", 32'(index_out), 0);
    flags("reset", 0, 1, 1);
    wr(0, 1); wr(1, 3); wr(2, 5); wr(3, 7);
    start(0, 4);
    chk("sorted_idx0", 32'(index_out), 0);
    flags("sorted0", 0, 0, 0);
    inc();
    chk("sorted_idx1", 32'(index_out), 1);
    flags("sorted1", 0, 0, 0);
    inc();
    chk("sorted_idx2", 32'(index_out), 2);
    flags("sorted2", 0, 1, 0);
    wr(0, 4); wr(1, 2);
    start(0, 2);
    flags("inversion", 1, 0, 0);
    wr(15, 9); wr(0, 1);
    start(15, 2);
    flags("wrap_pre", 1, 0, 0);
    wr_en = 1; wr_addr = 0; wr_data = 10;
    #1;
    flags("wrap_before_edge", 1, 0, 0);
    step();
    wr_en = 0;
    flags("wrap_after_write", 0, 1, 0);
    wr(0, 32'hFFFF_FFFF); wr(1, 1);
    start(0, 2);
`ifdef ARRAY_SORT_CHECK_SIGNED_EN
    flags("signed_cmp", 0, 1, 0);
`else
    flags("unsigned_cmp", 1, 0, 0);
`endif
    inc(); inc(); inc();
    chk("past_end_idx", 32'(index_out), 3);
    flags("past_end", 0, 1, 0);
    start(0, 1);
    flags("len1", 0, 1, 0);
    start(0, 0);
    flags("len0", 0, 1, 1);
    wr(0, 2); wr(1, 4); wr(2, 6); wr(3, 1);
    start(0, 8);
    inc(); inc(); inc();
    chk("midwalk_idx3", 32'(index_out), 3);
    reset = 1;
    step();
    reset = 0;
    chk("midreset_idx", 32'(index_out), 0);
    flags("midreset", 0, 1, 1);
    start(0, 4);
    flags("reload0", 0, 0, 0);
    inc(); inc();
    chk("reload_idx2", 32'(index_out), 2);
    flags("reload2", 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/array_sort_check_datapath.md
# array_sort_check_datapath

Datapath partner of the array sort-check control FSM. Holds the array under test in an internal word memory with a host write port, latches a base address and length, and walks an index across adjacent element pairs. Produces the three status flags the control FSM consumes: `inversion_found`, `end_of_array` and `zero_length_array`. It is driven directly by the FSM's `load_input`, `load_index` and `select_index` outputs.

## Interface

**Parameters**
- `WIDTH`, default 32: element data width.
- `ADDR_W`, default 4: memory address width. DEPTH = 2^ADDR_W words.

**Ports**
- `clock`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `load_input`, in, 1: latch `base_in` and `length_in`.
- `load_index`, in, 1: update the index register.
- `select_index`, in, 1: index source when loading. 0 selects 0; 1 selects index+1.
- `base_in`, in, ADDR_W: array start address.
- `length_in`, in, ADDR_W+1: element count, 0..DEPTH.
- `wr_en`, in, 1: host memory write enable.
- `wr_addr`, in, ADDR_W: host write address.
- `wr_data`, in, WIDTH: host write data.
- `inversion_found`, out, 1: current pair is out of order.
- `end_of_array`, out, 1: current pair is the last one (or no pair exists) and it is in order.
- `zero_length_array`, out, 1: latched length is 0.
- `index_out`, out, ADDR_W: current index register value.

## Operation

**Registers**
- `base_r` (ADDR_W), `len_r` (ADDR_W+1), `idx_r` (ADDR_W).
- `mem[DEPTH]` (WIDTH).

**Register updates** (priority top to bottom)
- `reset`: `base_r`, `len_r` and `idx_r` are cleared to 0. Memory is not cleared.
- `load_input`: `base_r` ← `base_in`; `len_r` ← `length_in`.
- `load_index`: `idx_r` ← `select_index` ? `idx_r`+1 : 0. The increment wraps modulo DEPTH.
- `load_input` and `load_index` are independent and may be asserted in the same cycle.
- `wr_en`: `mem[wr_addr]` ← `wr_data`. Writes are allowed in any cycle, including during a walk.

**Reads** (combinational, asynchronous)
- a = `mem[(base_r + idx_r) mod DEPTH]`
- b = `mem[(base_r + idx_r + 1) mod DEPTH]`
- Address wrap past DEPTH−1 to 0 is required behaviour.

**Flags** (combinational from registers and memory only, no control inputs)
- `pair_valid` = (idx_r + 2 ≤ len_r), evaluated in ADDR_W+2 bits so it never overflows.
- `inversion_found` = `pair_valid` & (a > b).
- `end_of_array` = (idx_r + 2 ≥ len_r) & ~`inversion_found`. The flags are mutually exclusive by design, so the FSM never sees inversion and end together.
- `zero_length_array` = (len_r == 0).

**Boundary cases**
- len 0: `zero_length_array` = 1, `end_of_array` = 1, `inversion_found` = 0.
- len 1: no pair exists; `end_of_array` = 1.
- `idx_r` past the end: `end_of_array` stays 1 and `inversion_found` stays 0.
- No state machine lives in this block; sequencing belongs entirely to the control FSM.

## Timing

- Reset values: `index_out` = 0, `zero_length_array` = 1, `end_of_array` = 1, `inversion_found` = 0.
- Flags reflect the registers and memory of the current cycle, with zero-cycle latency.
- A `load_index` issued in cycle n is visible on the flags in cycle n+1.
- A host write in cycle n is visible to reads in cycle n+1.
- Reset mid-walk: from the next cycle the outputs match the reset values. Memory contents are retained.
- A write to the address currently being read changes the flags only after the write edge.

## Configuration

- `ARRAY_SORT_CHECK_SIGNED_EN` defined: the comparison a > b is two's-complement signed.
- `ARRAY_SORT_CHECK_SIGNED_EN` not defined: the comparison is unsigned.
- Nothing else changes between the two builds.

## Test plan

- **Reset:** assert `reset` for 1 cycle → `index_out` = 0, `zero_length_array` = 1, `end_of_array` = 1, `inversion_found` = 0.
- **Sorted walk:** write [1,3,5,7] at 0..3; base 0, len 4; `load_input` + `load_index`(sel 0), then `load_index`(sel 1) once per cycle → `inversion_found` = 0 throughout; `end_of_array` = 0 at idx 0 and 1, and 1 at idx 2.
- **Inversion:** write [4,2]; base 0, len 2 → at idx 0, `inversion_found` = 1 and `end_of_array` = 0.
- **Address wrap:** ADDR_W = 4; `mem[15]` = 9, `mem[0]` = 1; base 15, len 2 → `inversion_found` = 1. Then write `mem[0]` = 10 → next cycle `inversion_found` = 0 and `end_of_array` = 1.
- **Signedness:** `mem[0]` = 0xFFFF_FFFF, `mem[1]` = 1; base 0, len 2 → with the macro, `inversion_found` = 0; without the macro, `inversion_found` = 1.
- **Reset mid-walk:** reach idx 3 with len 8, then pulse `reset` → next cycle `index_out` = 0 and `zero_length_array` = 1; a reload with base 0, len 4 re-reads the retained memory contents.
